bomba_sched: RTL and testbench

Pump scheduler for the watering subsystem: shares one pump between up to four pot zones, each with its own valve. It collects per-zone watering requests, picks one zone at a time by round-robin, and sequences valve-open, pump-run and drain. Pump run time is taken from that zone's pot size. It sits between the humidity/decision logic (which raises `regar` per zone) and the pump/valve drivers.

---
 rtl/bomba_sched_if.sv | 24 ++
 rtl/bomba_sched.sv | 158 +++++++++++++++
 tb/tb_bomba_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bomba_sched_if.sv
// Signal bundle between the watering decision logic and the pump scheduler.
// The master side raises requests and pot sizes; the slave side (scheduler) drives valves and pump.
interface bomba_sched_if #(
    parameter int N_ZONES = 4
);
    logic                   mod_bomba;
    logic [N_ZONES-1:0]     regar;
    logic [4*N_ZONES-1:0]   maceta;
    logic [N_ZONES-1:0]     valve;
    logic                   activar_b;
    logic                   busy;
    logic [1:0]             zone_id;
    logic [N_ZONES-1:0]     done;

    modport master (
        output mod_bomba, regar, maceta,
        input  valve, activar_b, busy, zone_id, done
    );

    modport slave (
        input  mod_bomba, regar, maceta,
        output valve, activar_b, busy, zone_id, done
    );
endinterface

// File: rtl/bomba_sched.sv
// Shares one pump among four pot zones: latch requests, grant one zone, run valve/pump/drain.
// Optional macro BOMBA_SCHED_PRIORITY_EN: fixed lowest-index priority instead of round-robin.
module bomba_sched #(
    parameter int N_ZONES       = 4,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int VALVE_SEC     = 1,
    parameter int SEC_PER_SIZE  = 30
) (
    input  logic         clk,
    input  logic         rst,
    bomba_sched_if.slave bus
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, VALVE, PUMP, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [6:0]     sec_q, sec_d;
    logic [6:0]     pump_sec_q, pump_sec_d;
    logic [1:0]     zone_q, zone_d;
    logic [1:0]     last_q, last_d;
    logic [3:0]     pending_q, pending_d;
    logic [3:0]     valve_q, valve_d;
    logic [3:0]     done_q, done_d;
    logic           pump_q, pump_d;
    logic           busy_q, busy_d;

    logic [3:0]     req_ok;
    logic           grant_vld;
    logic [1:0]     grant_idx;
    logic [3:0]     size_sel;
    logic [6:0]     sec_lim;
    logic           state_end;

    // A request only counts while the pump module is present and the pot size is 1..3.
    genvar gi;
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
        logic [3:0] size;
        assign size       = bus.maceta[4*gi +: 4];
        assign req_ok[gi] = bus.regar[gi] & bus.mod_bomba &
                            ((size == 4'd1) | (size == 4'd2) | (size == 4'd3));
    end

    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        grant_vld = 1'b0;
        grant_idx = 2'd0;
`ifdef BOMBA_SCHED_PRIORITY_EN
        for (int k = N_ZONES - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(k);
            end
        end
`else
        // Scan downward so the zone closest after last_q is the one left standing.
        for (int k = N_ZONES; k >= 1; k--) begin
            idx = 2'(int'(last_q) + k);
            if (pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
`endif
    end

    assign size_sel  = bus.maceta[{grant_idx, 2'b00} +: 4];
    assign sec_lim   = (state_q == PUMP) ? pump_sec_q : 7'(VALVE_SEC);
    assign state_end = (tick_q == TICK_MAX) && (sec_q == sec_lim - 7'd1);

    always_comb begin
        state_d    = state_q;
        zone_d     = zone_q;
        last_d     = last_q;
        pump_sec_d = pump_sec_q;
        done_d     = 4'b0000;

        if (state_q != IDLE && !bus.mod_bomba) begin
            // Interrupted zone keeps its pending bit and last_q stays put.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld && bus.mod_bomba) begin
                        state_d    = VALVE;
                        zone_d     = grant_idx;
                        pump_sec_d = 7'(int'(size_sel) * SEC_PER_SIZE);
                    end
                end
                VALVE: if (state_end) state_d = PUMP;
                PUMP:  if (state_end) state_d = DRAIN;
                DRAIN: begin
                    if (state_end) begin
                        state_d = IDLE;
                        done_d  = 4'b0001 << zone_q;
                        last_d  = zone_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pending_d = (pending_q | req_ok) & ~done_d;

        tick_d = tick_q;
        sec_d  = sec_q;
        if (state_d != state_q || state_q == IDLE) begin
            tick_d = '0;
            sec_d  = 7'd0;
        end else if (tick_q == TICK_MAX) begin
            tick_d = '0;
            sec_d  = sec_q + 7'd1;
        end else begin
            tick_d = tick_q + TW'(1);
        end

        valve_d = (state_d == IDLE) ? 4'b0000 : (4'b0001 << zone_d);
        pump_d  = (state_d == PUMP);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            sec_q      <= 7'd0;
            pump_sec_q <= 7'd0;
            zone_q     <= 2'd0;
            last_q     <= 2'd3;
            pending_q  <= 4'b0000;
            valve_q    <= 4'b0000;
            done_q     <= 4'b0000;
            pump_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            sec_q      <= sec_d;
            pump_sec_q <= pump_sec_d;
            zone_q     <= zone_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            valve_q    <= valve_d;
            done_q     <= done_d;
            pump_q     <= pump_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.valve     = valve_q;
    assign bus.activar_b = pump_q;
    assign bus.busy      = busy_q;
    assign bus.zone_id   = zone_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bomba_sched.sv
// Scenario bench for bomba_sched with a 10-cycle second; expected zone services are queued
// when requests are driven and compared as each valve/pump/drain sequence completes.
`timescale 1ns/1ps
module tb_bomba_sched;
    localparam int TPS = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bomba_sched_if bus ();

    bomba_sched #(
        .N_ZONES(4), .TICKS_PER_SEC(TPS), .VALVE_SEC(1), .SEC_PER_SIZE(30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0] zone;
        int         pump;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Observes one full service: waits for a valve, then counts valve-only, pump and drain cycles.
    task automatic measure(output bit ok, output int gap, output logic [1:0] z, output int vpre,
                           output int pcyc, output int vpost, output logic [3:0] dn, output bit clean);
        int n;
        n = 0; ok = 1'b0; gap = 0; z = 2'd0; vpre = 0; pcyc = 0; vpost = 0; dn = 4'b0; clean = 1'b1;
        while (bus.valve == 4'b0 && n < 3000) begin @(negedge clk); n++; end
        gap = n;
        if (bus.valve == 4'b0) return;
        z = bus.zone_id;
        while (bus.valve != 4'b0 && !bus.activar_b && n < 3000) begin
            if (bus.valve != (4'b0001 << z) || !bus.busy || bus.zone_id != z || bus.done != 4'b0) clean = 1'b0;
            vpre++; @(negedge clk); n++;
        end
        while (bus.activar_b && n < 3000) begin
            if (bus.valve != (4'b0001 << z) || !bus.busy || bus.zone_id != z || bus.done != 4'b0) clean = 1'b0;
            pcyc++; @(negedge clk); n++;
        end
        while (bus.valve != 4'b0 && !bus.activar_b && n < 3000) begin
            if (bus.valve != (4'b0001 << z) || !bus.busy || bus.zone_id != z || bus.done != 4'b0) clean = 1'b0;
            vpost++; @(negedge clk); n++;
        end
        if (bus.valve != 4'b0 || bus.busy || bus.activar_b) return;
        dn = bus.done;
        ok = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mod_bomba = 1'b1;
        bus.regar = 4'b0;
        bus.maceta = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mod_bomba = 1'b1;
        bus.regar = 4'b0;
        bus.maceta = 16'h0;
        repeat (3) @(negedge clk);
        checks++; if (bus.valve !== 4'b0) begin errors++; $display("FAIL reset_valve: got %b, want 0000", bus.valve); end
        checks++; if (bus.activar_b !== 1'b0) begin errors++; $display("FAIL reset_pump: got %b, want 0", bus.activar_b); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
        checks++; if (bus.zone_id !== 2'd0) begin errors++; $display("FAIL reset_zone: got %0d, want 0", bus.zone_id); end
        checks++; if (bus.done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b, want 0000", bus.done); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: valve=%b pump=%b busy=%b zone=%0d done=%b", bus.valve, bus.activar_b, bus.busy, bus.zone_id, bus.done);
    endtask

    task automatic test_single();
        bit ok, clean; int gap, vpre, pcyc, vpost; logic [1:0] z; logic [3:0] dn; exp_t e;
        bus.maceta = 16'h0001;
        bus.regar = 4'b0001;
        sb.push_back('{zone: 2'd0, pump: 300});
        @(negedge clk);
        bus.regar = 4'b0000;
        measure(ok, gap, z, vpre, pcyc, vpost, dn, clean);
        e = sb.pop_front();
        $display("single: zone=%0d gap=%0d valve=%0d pump=%0d drain=%0d done=%b", z, gap, vpre, pcyc, vpost, dn);
        checks++; if (gap != 1) begin errors++; $display("FAIL single_latency: got %0d, want 1", gap); end
        checks++;
        if (!ok || z !== e.zone || pcyc != e.pump || vpre != TPS || vpost != TPS || dn !== (4'b0001 << e.zone) || !clean) begin
            errors++;
            $display("FAIL single_txn: got ok=%0b zone=%0d valve=%0d pump=%0d drain=%0d done=%b clean=%0b, want zone=%0d valve=%0d pump=%0d drain=%0d done=%b",
                     ok, z, vpre, pcyc, vpost, dn, clean, e.zone, TPS, e.pump, TPS, 4'b0001 << e.zone);
        end
        checks++; if (vpre + pcyc + vpost + 1 != 321) begin errors++; $display("FAIL single_total: got %0d, want 321", vpre + pcyc + vpost + 1); end
        @(negedge clk);
        checks++; if (bus.done !== 4'b0) begin errors++; $display("FAIL single_done_width: got %b, want 0000", bus.done); end
    endtask

    task automatic test_round_robin();
        bit ok, clean; int gap, vpre, pcyc, vpost; logic [1:0] z; logic [3:0] dn; exp_t e;
        do_reset();
        bus.maceta = 16'h1321;
        bus.regar = 4'b1111;
        sb.push_back('{zone: 2'd0, pump: 300});
        sb.push_back('{zone: 2'd1, pump: 600});
        sb.push_back('{zone: 2'd2, pump: 900});
        sb.push_back('{zone: 2'd3, pump: 300});
        @(negedge clk);
        bus.regar = 4'b0000;
        while (sb.size() > 0) begin
            measure(ok, gap, z, vpre, pcyc, vpost, dn, clean);
            e = sb.pop_front();
            $display("rr: zone=%0d gap=%0d valve=%0d pump=%0d drain=%0d done=%b", z, gap, vpre, pcyc, vpost, dn);
            checks++;
            if (!ok || gap != 1 || z !== e.zone || pcyc != e.pump || vpre != TPS || vpost != TPS || dn !== (4'b0001 << e.zone) || !clean) begin
                errors++;
                $display("FAIL rr_txn: got ok=%0b gap=%0d zone=%0d valve=%0d pump=%0d drain=%0d done=%b clean=%0b, want gap=1 zone=%0d pump=%0d done=%b",
                         ok, gap, z, vpre, pcyc, vpost, dn, clean, e.zone, e.pump, 4'b0001 << e.zone);
            end
        end
    endtask

    task automatic test_invalid_size();
        bit ok, clean; int gap, vpre, pcyc, vpost; logic [1:0] z; logic [3:0] dn; exp_t e; int bad;
        do_reset();
        bus.maceta = 16'h0020;
        bus.regar = 4'b0110;
        sb.push_back('{zone: 2'd1, pump: 600});
        @(negedge clk);
        bus.regar = 4'b0100;
        measure(ok, gap, z, vpre, pcyc, vpost, dn, clean);
        e = sb.pop_front();
        $display("invalid: zone=%0d valve=%0d pump=%0d drain=%0d done=%b", z, vpre, pcyc, vpost, dn);
        checks++;
        if (!ok || z !== e.zone || pcyc != e.pump || dn !== (4'b0001 << e.zone) || !clean) begin
            errors++;
            $display("FAIL invalid_zone1: got ok=%0b zone=%0d pump=%0d done=%b clean=%0b, want zone=%0d pump=%0d done=%b",
                     ok, z, pcyc, dn, clean, e.zone, e.pump, 4'b0001 << e.zone);
        end
        bus.maceta = 16'h0520;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valve != 4'b0 || bus.busy) bad++;
        end
        bus.regar = 4'b0000;
        $display("invalid: zone2 size0/size5 active cycles=%0d", bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL invalid_zone2: got %0d active cycles, want 0", bad); end
    endtask

    task automatic test_interrupt();
        bit ok, clean; int gap, vpre, pcyc, vpost; logic [1:0] z; logic [3:0] dn; exp_t e; int n; int bad;
        do_reset();
        bus.maceta = 16'h1020;
        bus.regar = 4'b0010;
        @(negedge clk);
        bus.regar = 4'b0000;
        n = 0;
        while (!bus.activar_b && n < 100) begin @(negedge clk); n++; end
        checks++; if (!bus.activar_b) begin errors++; $display("FAIL intr_pump_start: got pump=%b after %0d cycles, want 1", bus.activar_b, n); end
        bus.regar = 4'b1000;
        @(negedge clk);
        bus.regar = 4'b0000;
        repeat (99) @(negedge clk);
        bus.mod_bomba = 1'b0;
        @(negedge clk);
        $display("intr: valve=%b pump=%b busy=%b done=%b", bus.valve, bus.activar_b, bus.busy, bus.done);
        checks++;
        if (bus.valve !== 4'b0 || bus.activar_b !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin
            errors++;
            $display("FAIL intr_off: got valve=%b pump=%b busy=%b done=%b, want all 0", bus.valve, bus.activar_b, bus.busy, bus.done);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.valve != 4'b0 || bus.busy || bus.done != 4'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL intr_hold: got %0d active cycles, want 0", bad); end
        bus.mod_bomba = 1'b1;
        sb.push_back('{zone: 2'd1, pump: 600});
        sb.push_back('{zone: 2'd3, pump: 300});
        while (sb.size() > 0) begin
            measure(ok, gap, z, vpre, pcyc, vpost, dn, clean);
            e = sb.pop_front();
            $display("intr resume: zone=%0d pump=%0d done=%b", z, pcyc, dn);
            checks++;
            if (!ok || z !== e.zone || pcyc != e.pump || dn !== (4'b0001 << e.zone) || !clean) begin
                errors++;
                $display("FAIL intr_resume: got ok=%0b zone=%0d pump=%0d done=%b clean=%0b, want zone=%0d pump=%0d done=%b",
                         ok, z, pcyc, dn, clean, e.zone, e.pump, 4'b0001 << e.zone);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n; int bad;
        do_reset();
        bus.maceta = 16'h0100;
        bus.regar = 4'b0100;
        @(negedge clk);
        bus.regar = 4'b0000;
        n = 0;
        while (!bus.activar_b && n < 100) begin @(negedge clk); n++; end
        checks++; if (!bus.activar_b) begin errors++; $display("FAIL rstmid_pump_start: got pump=%b, want 1", bus.activar_b); end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("rst mid: valve=%b pump=%b busy=%b zone=%0d done=%b", bus.valve, bus.activar_b, bus.busy, bus.zone_id, bus.done);
        checks++;
        if (bus.valve !== 4'b0 || bus.activar_b !== 1'b0 || bus.busy !== 1'b0 || bus.zone_id !== 2'd0 || bus.done !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_off: got valve=%b pump=%b busy=%b zone=%0d done=%b, want all 0",
                     bus.valve, bus.activar_b, bus.busy, bus.zone_id, bus.done);
        end
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (bus.valve != 4'b0 || bus.busy) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_pending: got %0d active cycles, want 0", bad); end
    endtask

    task automatic test_size_change();
        bit ok, clean; int gap, vpre, pcyc, vpost; logic [1:0] z; logic [3:0] dn; exp_t e; int n;
        bus.maceta = 16'h0001;
        bus.regar = 4'b0001;
        sb.push_back('{zone: 2'd0, pump: 300});
        @(negedge clk);
        bus.regar = 4'b0000;
        fork
            measure(ok, gap, z, vpre, pcyc, vpost, dn, clean);
            begin
                n = 0;
                while (!bus.activar_b && n < 100) begin @(negedge clk); n++; end
                repeat (20) @(negedge clk);
                bus.maceta = 16'h0003;
            end
        join
        e = sb.pop_front();
        $display("size change: zone=%0d pump=%0d done=%b", z, pcyc, dn);
        checks++;
        if (!ok || z !== e.zone || pcyc != e.pump || dn !== (4'b0001 << e.zone) || !clean) begin
            errors++;
            $display("FAIL size_change: got ok=%0b zone=%0d pump=%0d done=%b clean=%0b, want zone=%0d pump=%0d done=%b",
                     ok, z, pcyc, dn, clean, e.zone, e.pump, 4'b0001 << e.zone);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mod_bomba = 1'b1;
        bus.regar = 4'b0;
        bus.maceta = 16'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_invalid_size();
        test_interrupt();
        test_reset_mid();
        test_size_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
